load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Sits between the execute stage and the word-wide data memory. Accepts one RV32I load or
//   store request per handshake (LB/LH/LW/LBU/LHU, SB/SH/SW) on a byte address. Stores are
//   done as read-modify-write: the memory writes the whole word on mem_str.
//   Load data is returned lane-extracted and sign/zero-extended. Misaligned or illegal
//   requests get an error response and never touch memory.
// PARAMETERS
//   ADDR_W   12   word-address width of the data memory (depth = 2**ADDR_W words)
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous, active-low reset
//   req_valid      in   1       request present
//   req_ready      out  1       unit can accept; high only in IDLE
//   req_we         in   1       1 = store, 0 = load
//   req_funct3     in   3       RV32I funct3 of the load/store
//   req_addr       in   32      byte address; bits [ADDR_W+1:2] select word, upper bits ignored
//   req_wdata      in   32      store data (rs2), low bits used for SB/SH
//   rsp_valid      out  1       one-cycle response pulse, no backpressure
//   rsp_rdata      out  32      extended load data; 0 for stores and errors
//   rsp_err        out  1       misaligned/illegal request; valid with rsp_valid
//   mem_addr       out  ADDR_W  word address to data memory
//   mem_wdata      out  32      merged word to write
//   mem_str        out  1       memory write strobe
//   mem_byte_mask  out  2       byte lane = latched addr[1:0] (SH: {addr[1],1'b0}; SW: 2'b00)
//   mem_rdata      in   32      combinational read data for mem_addr
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, all latches 0. rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   mem_str=0, mem_addr=0, mem_wdata=0, mem_byte_mask=0. req_ready=1 once rst_n releases.
//   FSM states: IDLE, RD, WR, RSP. All outputs decode from registers, so mem_str is glitch-free.
//   IDLE:
//     - req_ready=1. On req_valid, latch we, funct3, addr, wdata.
//     - If the request is illegal, go to RSP with err=1. Illegal means: load funct3 in
//       {011,110,111}; store funct3 >= 011; half access with addr[0]=1; word access with
//       addr[1:0]!=0.
//     - Otherwise go to RD.
//   RD: mem_addr = latched addr[ADDR_W+1:2]; capture mem_rdata into rd_q at the clock edge.
//     Load -> RSP. Store -> WR. SW also passes through RD and WR, so latency is uniform.
//   WR: mem_str=1 for exactly this one cycle; mem_addr unchanged; mem_wdata = merge(rd_q):
//     - SB: replace byte lane addr[1:0] with wdata[7:0].
//     - SH: replace half addr[1] with wdata[15:0].
//     - SW: wdata.
//     Then go to RSP.
//   RSP: rsp_valid=1 for one cycle; go to IDLE. req_ready=0, so no back-to-back accept.
//     rsp_rdata is registered and is 0 for stores and errors. For loads:
//     - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
//     - LH/LHU: half addr[1], sign- or zero-extended.
//     - LW: rd_q.
//   Latency, counted from the accept edge N:
//     - load:  rsp_valid in the cycle after edge N+1
//     - store: rsp_valid in the cycle after edge N+2; the write commits at edge N+2
//     - error: rsp_valid in the cycle after edge N
//   req_valid is ignored outside IDLE. Inputs only need to be stable at the accept edge.
//   mem_addr and mem_wdata hold their last values outside RD/WR. mem_str=0 outside WR.
//   Reset in any state returns to IDLE immediately. In WR, mem_str drops asynchronously and the
//   write is abandoned; partial-word corruption must not occur.
//   Address wrap: word address ADDR_W'h...FFF is legal. Upper address bits alias and do not
//   cause an error.
// TESTING
//   1. Memory word 5 = 32'h8899AABB. LB at byte address 0x15 -> rsp_rdata=32'hFFFFFFAA,
//      err=0, rsp_valid two edges after accept.
//   2. Same word, LHU at 0x16 -> 32'h00008899. LH at 0x16 -> 32'hFFFF8899. LW at 0x14
//      -> 32'h8899AABB.
//   3. SB wdata=32'h12345677 at 0x17, word 5 = 32'h8899AABB -> one mem_str pulse;
//      word 5 becomes 32'h7799AABB; rsp_rdata=0.
//   4. SH at 0x13 and LW at 0x12 -> rsp_err=1 one edge after accept; mem_str never asserts;
//      memory unchanged.
//   5. SW 32'hDEADBEEF at 0x3FFC (ADDR_W=12, top word) -> word 4095 = 32'hDEADBEEF. A
//      following LW returns the same value; req_ready=0 from accept through RSP.
//   6. rst_n pulsed low during WR -> mem_str=0 asynchronously; target word unchanged;
//      state IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Bridges the execute stage to a word-wide data memory for RV32I loads and
//   stores (LB/LH/LW/LBU/LHU, SB/SH/SW). One request is taken per handshake.
//   Stores are read-modify-write: the word is read, the addressed lanes are
//   merged with the store data, and the whole word is written back. Illegal
//   or misaligned requests return an error and never touch memory.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I funct3
//   req_addr          byte address; upper bits alias
//   req_wdata         store data
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         extended load data (0 for stores/errors)
//   rsp_err           illegal/misaligned request flag
//   mem_addr          word address to memory
//   mem_wdata         merged word for the write
//   mem_str           write strobe, one cycle per store
//   mem_byte_mask     lane of the access (low address bits, size-aligned)
//   mem_rdata         combinational read data for mem_addr
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_str,
  output logic [1:0]        mem_byte_mask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Upper address bits alias onto the memory and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad_f3;
    if (we) bad_f3 = (f3 >= 3'b011);
    else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return bad_f3 || ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [1:0] lane_mask(input logic [2:0] f3,
                                           input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b);             // LB: signed cast sign-extends
      3'b001:  return 32'(h);             // LH
      3'b100:  return {24'h0, b};         // LBU
      3'b101:  return {16'h0, h};         // LHU
      default: return word;               // LW
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    case (f3[1:0])
      2'b00: m[{a, 3'b000} +: 8] = wd[7:0];
      2'b01: if (a[1]) m[31:16] = wd[15:0];
             else      m[15:0]  = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  // Every output is a register, so mem_str cannot glitch. The read word is
  // consumed at the RD edge (merged or extended straight into the output
  // registers), which makes a separate copy of it unnecessary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= 32'h0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      mem_str       <= 1'b0;
      mem_byte_mask <= 2'b00;
    end else begin
      case (state)
        // accept edge
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RSP;
            end else begin
              mem_addr      <= req_addr[ADDR_W+1:2];
              mem_byte_mask <= lane_mask(req_funct3, req_addr[1:0]);
              state         <= RD;
            end
          end
        end
        // read edge: memory word is sampled here
        RD: begin
          if (we_q) begin
            mem_wdata <= store_merge(f3_q, lane_q, mem_rdata, wdata_q);
            mem_str   <= 1'b1;
            state     <= WR;
          end else begin
            rsp_rdata <= load_extend(f3_q, lane_q, mem_rdata);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        // write edge: memory commits mem_wdata here
        WR: begin
          mem_str   <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        // response edge
        RSP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a behavioural word memory.
//   Expected responses are queued when a request is driven and compared when
//   the unit raises rsp_valid.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_str;
  logic [1:0]        mem_byte_mask;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_str(mem_str),
    .mem_byte_mask(mem_byte_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory with a backdoor write port for preloading.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = 32'h0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_str)    mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr]  <= bd_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drive one request, then wait (bounded) for the response and check it.
  // exp_lat counts clock edges after the accept edge before rsp_valid shows.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_str,
                        input logic [1:0] exp_mask);
    exp_t e;
    int   lat;
    int   nstr;
    logic got;
    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    exp_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the unit must have latched them.
    req_valid = 1'b0; req_funct3 = 3'b111; req_addr = 32'h0;
    req_wdata = $urandom;
    if (!exp_err) check({tag, ".mask"}, 32'(mem_byte_mask), 32'(exp_mask));
    got = 1'b0; lat = 0; nstr = 0;
    for (int k = 0; k < 8; k++) begin
      if (mem_str) nstr++;
      check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        got = 1'b1; lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".rsp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, ".latency"}, lat, exp_lat);
      if (exp_q.size() == 0) begin
        check({tag, ".queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, ".rdata"}, rsp_rdata, e.rdata);
        check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
      end
    end
    check({tag, ".str_pulses"}, nstr, exp_str);
    @(posedge clk);
    #1;
    check({tag, ".rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_err", 32'(rsp_err), 32'd0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.mem_str", 32'(mem_str), 32'd0);
    check("reset.mem_addr", 32'(mem_addr), 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.mask", 32'(mem_byte_mask), 32'd0);

    preload(12'd5, 32'h8899AABB);
    preload(12'd4, 32'h01020304);

    // Loads from word 5
    do_req("lb15",  1'b0, 3'b000, 32'h15, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 0, 2'b01);
    do_req("lbu15", 1'b0, 3'b100, 32'h15, 32'h0, 32'h000000AA, 1'b0, 1, 0, 2'b01);
    do_req("lb14",  1'b0, 3'b000, 32'h14, 32'h0, 32'hFFFFFFBB, 1'b0, 1, 0, 2'b00);
    do_req("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h00000088, 1'b0, 1, 0, 2'b11);
    do_req("lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008899, 1'b0, 1, 0, 2'b10);
    do_req("lh16",  1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 1, 0, 2'b10);
    do_req("lh14",  1'b0, 3'b001, 32'h14, 32'h0, 32'hFFFFAABB, 1'b0, 1, 0, 2'b00);
    do_req("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 1, 0, 2'b00);

    // Read-modify-write stores
    do_req("sb17", 1'b1, 3'b000, 32'h17, 32'h12345677, 32'h0, 1'b0, 2, 1, 2'b11);
    check("sb17.mem5", mem[5], 32'h7799AABB);
    do_req("sh14", 1'b1, 3'b001, 32'h14, 32'h5555CAFE, 32'h0, 1'b0, 2, 1, 2'b00);
    check("sh14.mem5", mem[5], 32'h7799CAFE);
    check("sh14.mem4", mem[4], 32'h01020304);

    // Illegal / misaligned requests
    do_req("sh13",  1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 0, 2'b00);
    check("sh13.mem4", mem[4], 32'h01020304);
    do_req("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0, 0, 2'b00);
    do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0, 0, 2'b00);
    do_req("st100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 0, 2'b00);
    check("st100.mem4", mem[4], 32'h01020304);

    // Top word and address aliasing
    do_req("sw_top", 1'b1, 3'b010, 32'h3FFC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 2'b00);
    check("sw_top.mem4095", mem[4095], 32'hDEADBEEF);
    do_req("lw_top",   1'b0, 3'b010, 32'h3FFC, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 2'b00);
    do_req("lw_alias", 1'b0, 3'b010, 32'hFFFF_3FFC, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 2'b00);

    // Reset asserted while the write strobe is high
    preload(12'd7, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h1C; req_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstwr.str_in_rd", 32'(mem_str), 32'd0);
    @(posedge clk);
    #1;
    check("rstwr.str_in_wr", 32'(mem_str), 32'd1);
    check("rstwr.merged", mem_wdata, 32'h112233FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwr.str_async", 32'(mem_str), 32'd0);
    check("rstwr.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rstwr.mem7", mem[7], 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstwr.ready", 32'(req_ready), 32'd1);
    check("rstwr.rsp_idle", 32'(rsp_valid), 32'd0);
    do_req("lw_after_rst", 1'b0, 3'b010, 32'h1C, 32'h0, 32'h11223344, 1'b0, 1, 0, 2'b00);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
